// File: rtl/looper_pkg.sv
// Shared definitions for the memory-dump path: FSM encodings, default widths and
// the SPART command byte that triggers a dump.
package looper_pkg;

    localparam int         DUMP_ADDR_W    = 14;
    localparam logic [7:0] SPART_CMD_DUMP = 8'h44;

    typedef enum logic [3:0] {
        DUMP_IDLE  = 4'd0,
        DUMP_ARB   = 4'd1,
        DUMP_LOAD  = 4'd2,
        DUMP_WAIT  = 4'd3,
        DUMP_LATCH = 4'd4,
        DUMP_SEND  = 4'd5,
        DUMP_NEXT  = 4'd6,
        DUMP_DONE  = 4'd7
    } dump_state_e;

endpackage

// File: rtl/dump_byte_ser.sv
// Word-to-byte serializer: presents a captured word MSB byte first on a
// valid/ready byte interface and flags acceptance of the final byte.
module dump_byte_ser
    import looper_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] din,
    input  logic              tx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    output logic              last_byte,
    output logic              last_acc
);

    localparam int NBYTES = DATA_W / 8;
    localparam int BI_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic [DATA_W-1:0] word_q;
    logic [BI_W-1:0]   byte_idx;

    // The word shifts left on every accepted byte so the outgoing byte is always the top slice.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q   <= '0;
            byte_idx <= '0;
            tx_valid <= 1'b0;
        end else if (clear) begin
            byte_idx <= '0;
            tx_valid <= 1'b0;
        end else if (load) begin
            word_q   <= din;
            byte_idx <= '0;
            tx_valid <= 1'b1;
        end else if (tx_valid && tx_ready) begin
            if (last_byte) begin
                tx_valid <= 1'b0;
            end else begin
                byte_idx <= byte_idx + 1'b1;
                word_q   <= word_q << 8;
            end
        end
    end

    assign tx_data   = word_q[DATA_W-1 -: 8];
    assign last_byte = (byte_idx == BI_W'(NBYTES - 1));
    assign last_acc  = tx_valid && tx_ready && last_byte;

endmodule

// File: rtl/mem_dump_seq.sv
// Streams an inclusive word range of RAM port B to the SPART transmitter,
// owning port B through a req/gnt handshake for the whole dump.
module mem_dump_seq
    import looper_pkg::*;
#(
    parameter int ADDR_W = DUMP_ADDR_W,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] stop_addr,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic [ADDR_W-1:0] mem_addrb,
    output logic              mem_enb,
    output logic              mem_web,
    input  logic [DATA_W-1:0] mem_doutb,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done,
    output logic              range_err,
    output logic [3:0]        state
);

    dump_state_e       state_q;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] stop_q;
    logic [1:0]        wait_cnt;
    logic              ser_load;
    logic              ser_clear;
    logic              last_byte;
    logic              last_acc;

    assign ser_load  = (state_q == DUMP_LATCH);
    assign ser_clear = abort && (state_q != DUMP_IDLE);
    assign mem_web   = 1'b0;
    assign state     = state_q;

    dump_byte_ser #(
        .DATA_W (DATA_W)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (ser_load),
        .clear     (ser_clear),
        .din       (mem_doutb),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .last_byte (last_byte),
        .last_acc  (last_acc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DUMP_IDLE;
            cur_addr  <= '0;
            stop_q    <= '0;
            wait_cnt  <= '0;
            mem_req   <= 1'b0;
            mem_enb   <= 1'b0;
            mem_addrb <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            range_err <= 1'b0;
        end else begin
            done      <= 1'b0;
            range_err <= 1'b0;
            mem_enb   <= 1'b0;
            if (abort && state_q != DUMP_IDLE) begin
                state_q <= DUMP_IDLE;
                mem_req <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state_q)
                    DUMP_IDLE: begin
                        if (start) begin
                            if (stop_addr >= start_addr) begin
                                cur_addr <= start_addr;
                                stop_q   <= stop_addr;
                                busy     <= 1'b1;
                                mem_req  <= 1'b1;
                                state_q  <= DUMP_ARB;
                            end else begin
                                range_err <= 1'b1;
                            end
                        end
                    end
                    DUMP_ARB: begin
                        if (mem_gnt) begin
                            mem_addrb <= cur_addr;
                            mem_enb   <= 1'b1;
                            state_q   <= DUMP_LOAD;
                        end
                    end
                    DUMP_LOAD: begin
                        wait_cnt <= '0;
                        state_q  <= (RD_LAT == 1) ? DUMP_LATCH : DUMP_WAIT;
                    end
                    DUMP_WAIT: begin
                        if (wait_cnt == 2'(RD_LAT - 2)) begin
                            state_q <= DUMP_LATCH;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    DUMP_LATCH: state_q <= DUMP_SEND;
                    DUMP_SEND: begin
                        if (last_acc) begin
                            state_q <= DUMP_NEXT;
                        end
                    end
                    // Compare before increment so a range ending at the top address never wraps.
                    DUMP_NEXT: begin
                        if (cur_addr == stop_q) begin
                            mem_req <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_q <= DUMP_DONE;
                        end else if (mem_gnt) begin
                            cur_addr  <= cur_addr + 1'b1;
                            mem_addrb <= cur_addr + 1'b1;
                            mem_enb   <= 1'b1;
                            state_q   <= DUMP_LOAD;
                        end
                    end
                    DUMP_DONE: state_q <= DUMP_IDLE;
                    default:   state_q <= DUMP_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_dump_seq.sv
// Directed bench for mem_dump_seq: table of dump ranges plus hand-written
// sequences for delayed grant, abort and a top-of-memory dump with RD_LAT=2.
module tb_mem_dump_seq;

    logic        clk = 1'b0;
    logic        rst, start, abort, mem_gnt, tx_ready;
    logic [13:0] start_addr, stop_addr;

    logic        mem_req, mem_enb, mem_web, tx_valid, busy, done, range_err;
    logic [13:0] mem_addrb;
    logic [31:0] mem_doutb;
    logic [7:0]  tx_data;
    logic [3:0]  state;

    logic        mem_req2, mem_enb2, mem_web2, tx_valid2, busy2, done2, range_err2;
    logic [13:0] mem_addrb2;
    logic [31:0] mem_doutb2;
    logic [7:0]  tx_data2;
    logic [3:0]  state2;

    always #5 clk = ~clk;

    mem_dump_seq #(.ADDR_W(14), .DATA_W(32), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .start_addr(start_addr), .stop_addr(stop_addr),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addrb(mem_addrb),
        .mem_enb(mem_enb), .mem_web(mem_web), .mem_doutb(mem_doutb),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done), .range_err(range_err), .state(state)
    );

    mem_dump_seq #(.ADDR_W(14), .DATA_W(32), .RD_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .start_addr(start_addr), .stop_addr(stop_addr),
        .mem_req(mem_req2), .mem_gnt(mem_gnt), .mem_addrb(mem_addrb2),
        .mem_enb(mem_enb2), .mem_web(mem_web2), .mem_doutb(mem_doutb2),
        .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready),
        .busy(busy2), .done(done2), .range_err(range_err2), .state(state2)
    );

    function automatic logic [31:0] memval(input logic [13:0] a);
        if (a == 14'd12) return 32'hDEADBEEF;
        return {a[7:0], a[13:6], a[7:0] ^ 8'hA5, 8'h5A};
    endfunction

    // Port-B models: latency 1 and latency 2
    logic        en_d;
    logic [13:0] a_d;
    always @(posedge clk) begin
        if (mem_enb) mem_doutb <= memval(mem_addrb);
        en_d <= mem_enb2;
        a_d  <= mem_addrb2;
        if (en_d) mem_doutb2 <= memval(a_d);
    end

    int rmode = 0;
    int rcnt  = 0;
    always @(posedge clk) begin
        #1;
        rcnt++;
        tx_ready = (rmode == 0) ? 1'b1 : (rcnt % 3 == 0);
    end

    logic [7:0] q1[$];
    logic [7:0] q2[$];
    int enb1, enb2, done_n1, done_n2, err_n1, req_seen, busy_seen, wait2, stab_viol;
    logic       hold;
    logic [7:0] held;

    always @(negedge clk) begin
        if (tx_valid && tx_ready)  q1.push_back(tx_data);
        if (tx_valid2 && tx_ready) q2.push_back(tx_data2);
        if (mem_enb)     enb1++;
        if (mem_enb2)    enb2++;
        if (done)        done_n1++;
        if (done2)       done_n2++;
        if (range_err)   err_n1++;
        if (mem_req)     req_seen++;
        if (busy)        busy_seen++;
        if (state2 == 4'd3) wait2++;
        if (hold && (!tx_valid || tx_data != held)) stab_viol++;
        hold = tx_valid && !tx_ready;
        held = tx_data;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        q1.delete(); q2.delete();
        enb1 = 0; enb2 = 0; done_n1 = 0; done_n2 = 0; err_n1 = 0;
        req_seen = 0; busy_seen = 0; wait2 = 0; stab_viol = 0; hold = 1'b0;
    endtask

    task automatic do_start(input logic [13:0] s, input logic [13:0] e);
        @(posedge clk); #1;
        start_addr = s; stop_addr = e; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int i;
        for (i = 0; i < max; i++) begin
            @(negedge clk);
            if (state == 4'd0 && state2 == 4'd0) break;
        end
        total++;
        if (i >= max) begin
            bad++;
            $display("FAIL idle_timeout: waited %0d cycles, state=%0d state2=%0d", i, state, state2);
        end
    endtask

    task automatic check_stream(input bit second, input logic [13:0] s, input int nwords);
        int n;
        logic [31:0] w;
        n = second ? q2.size() : q1.size();
        check(second ? "byte_count2" : "byte_count", n, nwords * 4);
        for (int k = 0; k < n && k < nwords * 4; k++) begin
            w = memval(14'(s + k / 4));
            check(second ? "byte2" : "byte", second ? q2[k] : q1[k], 8'(w >> (24 - 8 * (k % 4))));
        end
    endtask

    typedef struct {
        logic [13:0] s;
        logic [13:0] e;
        int          rmode;
        logic        err;
    } vec_t;

    vec_t tbl[5];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nw;
        tbl[0] = '{14'd12,  14'd12,  0, 1'b0};
        tbl[1] = '{14'd12,  14'd16,  1, 1'b0};
        tbl[2] = '{14'd20,  14'd19,  0, 1'b1};
        tbl[3] = '{14'd5,   14'd5,   1, 1'b0};
        tbl[4] = '{14'd100, 14'd103, 0, 1'b0};

        rst = 1'b1; start = 1'b0; abort = 1'b0; mem_gnt = 1'b1; tx_ready = 1'b1;
        start_addr = '0; stop_addr = '0;
        clear_mon();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outs", {mem_req, mem_enb, mem_web, tx_valid, busy, done, range_err, state, tx_data},
              '0);
        check("reset_addrb", mem_addrb, 14'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int t = 0; t < 5; t++) begin
            clear_mon();
            rmode = tbl[t].rmode;
            do_start(tbl[t].s, tbl[t].e);
            wait_idle(2000);
            repeat (2) @(negedge clk);
            nw = tbl[t].err ? 0 : int'(tbl[t].e - tbl[t].s) + 1;
            check_stream(1'b0, tbl[t].s, nw);
            check_stream(1'b1, tbl[t].s, nw);
            check("enb_count", enb1, nw);
            check("done_count", done_n1, tbl[t].err ? 0 : 1);
            check("range_err_count", err_n1, tbl[t].err ? 1 : 0);
            check("req_seen", req_seen != 0, !tbl[t].err);
            check("busy_seen", busy_seen != 0, !tbl[t].err);
            check("tx_stable", stab_viol, 0);
            check("busy_after", busy, 1'b0);
        end

        // Grant held off for 10 cycles
        clear_mon();
        rmode = 0;
        mem_gnt = 1'b0;
        do_start(14'd0, 14'd1);
        nw = 0;
        repeat (10) begin
            @(negedge clk);
            if (state == 4'd1 && !mem_enb && mem_req) nw++;
        end
        check("arb_cycles", nw, 10);
        check("enb_before_gnt", enb1, 0);
        @(posedge clk); #1;
        mem_gnt = 1'b1;
        wait_idle(500);
        check_stream(1'b0, 14'd0, 2);
        check("gnt_enb_count", enb1, 2);
        check("gnt_done_count", done_n1, 1);

        // Abort while the third byte of word 13 is on the wire
        clear_mon();
        do_start(14'd12, 14'd16);
        nw = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (q1.size() >= 6) break;
            nw++;
        end
        check("abort_reach", nw < 300, 1'b1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_state", state, 4'd0);
        check("abort_outs", {tx_valid, mem_req, mem_enb, busy, done}, 5'b0);
        check("abort_state2", state2, 4'd0);
        repeat (3) @(negedge clk);
        check("abort_done", done_n1, 0);
        check("abort_bytes", q1.size(), 7);
        if (q1.size() == 7) check("abort_last_byte", q1[6], 8'(memval(14'd13) >> 8));
        clear_mon();
        do_start(14'd20, 14'd20);
        wait_idle(500);
        check_stream(1'b0, 14'd20, 1);
        check("restart_done", done_n1, 1);

        // Top-of-memory single word with read latency 2
        clear_mon();
        do_start(14'd16383, 14'd16383);
        wait_idle(500);
        repeat (2) @(negedge clk);
        check_stream(1'b1, 14'd16383, 1);
        check("top_wait_cycles", wait2, 1);
        check("top_done2", done_n2, 1);
        check("top_enb2", enb2, 1);
        check("top_addrb2", mem_addrb2, 14'd16383);
        check_stream(1'b0, 14'd16383, 1);
        check("top_addrb", mem_addrb, 14'd16383);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
